// File: rtl/warp_sched_pkg.sv
// rtl/warp_sched_pkg.sv - shared pipe/warp state encodings and counter width
package warp_sched_pkg;

  // Shared pipe state; the encoding is visible on core_state
  typedef enum logic [2:0] {
    PIPE_IDLE    = 3'd0,
    PIPE_SELECT  = 3'd1,
    PIPE_FETCH   = 3'd2,
    PIPE_DECODE  = 3'd3,
    PIPE_REQUEST = 3'd4,
    PIPE_EXECUTE = 3'd5,
    PIPE_UPDATE  = 3'd6,
    PIPE_DONE    = 3'd7
  } pipe_state_t;

  // Per-warp scheduling state
  typedef enum logic [2:0] {
    W_INACTIVE = 3'd0,
    W_READY    = 3'd1,
    W_MEMWAIT  = 3'd2,
    W_WB       = 3'd3,
    W_DONE     = 3'd4
  } warp_state_t;

  localparam int CNT_BITS = 32;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at a pointer
module rr_arbiter #(
  parameter int N        = 4,
  parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic                grant_valid,
  output logic [IDX_BITS-1:0] grant_index
);

  int                  idx;
  logic [IDX_BITS-1:0] idx_l;

  // Walk from the farthest offset back to ptr so the closest requester wins
  always_comb begin
    grant_valid = 1'b0;
    grant_index = '0;
    idx         = 0;
    idx_l       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx   = (int'(ptr) + k) % N;
      idx_l = IDX_BITS'(idx);
      if (req[idx_l]) begin
        grant_valid = 1'b1;
        grant_index = idx_l;
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// rtl/warp_scheduler.sv - multi-warp issue controller over one shared pipe
module warp_scheduler
  import warp_sched_pkg::*;
#(
  parameter int NUM_WARPS    = 4,
  parameter int PC_BITS      = 8,
  parameter int WARP_ID_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [WARP_ID_BITS:0]   warp_count,
  output logic                    done,
  output logic [2:0]              core_state,
  output logic [WARP_ID_BITS-1:0] active_warp,
  output logic [PC_BITS-1:0]      current_pc,
  output logic                    fetch_req_valid,
  input  logic                    fetch_done,
  input  logic                    decoded_mem_read_enable,
  input  logic                    decoded_mem_write_enable,
  input  logic                    decoded_ret,
  input  logic [PC_BITS-1:0]      next_pc,
  output logic                    mem_req_valid,
  input  logic [NUM_WARPS-1:0]    mem_done,
  output logic                    wb_from_mem,
  output logic [CNT_BITS-1:0]     issued_count,
  output logic [CNT_BITS-1:0]     stall_cycles
);

  pipe_state_t             pipe_q, pipe_d;
  warp_state_t             warp_state_q [NUM_WARPS];
  warp_state_t             warp_state_d [NUM_WARPS];
  logic [PC_BITS-1:0]      warp_pc_q [NUM_WARPS];
  logic [PC_BITS-1:0]      warp_pc_d [NUM_WARPS];
  logic [WARP_ID_BITS-1:0] active_warp_q, active_warp_d;
  logic [WARP_ID_BITS-1:0] ptr_q, ptr_d;
  logic [PC_BITS-1:0]      current_pc_q, current_pc_d;
  logic                    wb_from_mem_q, wb_from_mem_d;
  logic [CNT_BITS-1:0]     issued_q, issued_d;
  logic [CNT_BITS-1:0]     stall_q, stall_d;

  logic [NUM_WARPS-1:0]    wb_req, rdy_req;
  logic                    any_live;
  logic                    wb_gv, rdy_gv;
  logic [WARP_ID_BITS-1:0] wb_gi, rdy_gi;

  // Request vectors for the two arbiters and the "anything still running" flag
  always_comb begin
    wb_req   = '0;
    rdy_req  = '0;
    any_live = 1'b0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      wb_req[i]  = (warp_state_q[i] == W_WB);
      rdy_req[i] = (warp_state_q[i] == W_READY);
      if (warp_state_q[i] == W_READY || warp_state_q[i] == W_MEMWAIT ||
          warp_state_q[i] == W_WB)
        any_live = 1'b1;
    end
  end

  rr_arbiter #(.N(NUM_WARPS), .IDX_BITS(WARP_ID_BITS)) u_wb_arb (
    .req(wb_req), .ptr(ptr_q), .grant_valid(wb_gv), .grant_index(wb_gi)
  );

  rr_arbiter #(.N(NUM_WARPS), .IDX_BITS(WARP_ID_BITS)) u_rdy_arb (
    .req(rdy_req), .ptr(ptr_q), .grant_valid(rdy_gv), .grant_index(rdy_gi)
  );

  // Next-state logic: memory completions first, then the pipe step for the active warp
  always_comb begin
    pipe_d        = pipe_q;
    warp_state_d  = warp_state_q;
    warp_pc_d     = warp_pc_q;
    active_warp_d = active_warp_q;
    ptr_d         = ptr_q;
    current_pc_d  = current_pc_q;
    wb_from_mem_d = wb_from_mem_q;
    issued_d      = issued_q;
    stall_d       = stall_q;

    // A pulse only counts for a warp already parked; the active warp is never parked
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (warp_state_q[i] == W_MEMWAIT && mem_done[i])
        warp_state_d[i] = W_WB;
    end

    case (pipe_q)
      PIPE_IDLE: begin
        if (start) begin
          if (warp_count == '0) begin
            pipe_d = PIPE_DONE;
          end else begin
            for (int i = 0; i < NUM_WARPS; i++) begin
              warp_state_d[i] = (i < int'(warp_count)) ? W_READY : W_INACTIVE;
              warp_pc_d[i]    = '0;
            end
            pipe_d = PIPE_SELECT;
          end
        end
      end
      PIPE_SELECT: begin
        if (wb_gv) begin
          active_warp_d = wb_gi;
          current_pc_d  = warp_pc_q[wb_gi];
          ptr_d         = WARP_ID_BITS'((int'(wb_gi) + 1) % NUM_WARPS);
          wb_from_mem_d = 1'b1;
          pipe_d        = PIPE_UPDATE;
        end else if (rdy_gv) begin
          active_warp_d = rdy_gi;
          current_pc_d  = warp_pc_q[rdy_gi];
          ptr_d         = WARP_ID_BITS'((int'(rdy_gi) + 1) % NUM_WARPS);
          wb_from_mem_d = 1'b0;
          pipe_d        = PIPE_FETCH;
        end else if (!any_live) begin
          pipe_d = PIPE_DONE;
        end else begin
          stall_d = stall_q + CNT_BITS'(1);
        end
      end
      PIPE_FETCH: begin
        if (fetch_done) pipe_d = PIPE_DECODE;
      end
      PIPE_DECODE: begin
        issued_d = issued_q + CNT_BITS'(1);
        if (decoded_ret) begin
          warp_state_d[active_warp_q] = W_DONE;
          pipe_d                      = PIPE_SELECT;
        end else if (decoded_mem_read_enable || decoded_mem_write_enable) begin
          pipe_d = PIPE_REQUEST;
        end else begin
          pipe_d = PIPE_EXECUTE;
        end
      end
      PIPE_REQUEST: begin
        warp_state_d[active_warp_q] = W_MEMWAIT;
        pipe_d                      = PIPE_SELECT;
      end
      PIPE_EXECUTE: begin
        pipe_d = PIPE_UPDATE;
      end
      PIPE_UPDATE: begin
        warp_state_d[active_warp_q] = W_READY;
        warp_pc_d[active_warp_q]    = wb_from_mem_q ?
                                      (warp_pc_q[active_warp_q] + PC_BITS'(1)) : next_pc;
        wb_from_mem_d               = 1'b0;
        pipe_d                      = PIPE_SELECT;
      end
      default: begin
        pipe_d = PIPE_DONE;
      end
    endcase
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_q        <= PIPE_IDLE;
      active_warp_q <= '0;
      ptr_q         <= '0;
      current_pc_q  <= '0;
      wb_from_mem_q <= 1'b0;
      issued_q      <= '0;
      stall_q       <= '0;
      for (int i = 0; i < NUM_WARPS; i++) begin
        warp_state_q[i] <= W_INACTIVE;
        warp_pc_q[i]    <= '0;
      end
    end else begin
      pipe_q        <= pipe_d;
      active_warp_q <= active_warp_d;
      ptr_q         <= ptr_d;
      current_pc_q  <= current_pc_d;
      wb_from_mem_q <= wb_from_mem_d;
      issued_q      <= issued_d;
      stall_q       <= stall_d;
      warp_state_q  <= warp_state_d;
      warp_pc_q     <= warp_pc_d;
    end
  end

  assign core_state      = pipe_q;
  assign done            = (pipe_q == PIPE_DONE);
  assign fetch_req_valid = (pipe_q == PIPE_FETCH);
  assign mem_req_valid   = (pipe_q == PIPE_REQUEST);
  assign active_warp     = active_warp_q;
  assign current_pc      = current_pc_q;
  assign wb_from_mem     = wb_from_mem_q;
  assign issued_count    = issued_q;
  assign stall_cycles    = stall_q;

endmodule

// File: tb/tb_warp_scheduler.sv
// tb/tb_warp_scheduler.sv - self-checking bench for warp_scheduler
module tb_warp_scheduler;

  localparam int NW  = 4;
  localparam int PCB = 8;
  localparam int IDB = 2;

  localparam int S_IDLE = 0, S_SELECT = 1, S_FETCH = 2, S_DECODE = 3;
  localparam int S_REQUEST = 4, S_EXECUTE = 5, S_UPDATE = 6, S_DONE = 7;
  localparam int M_INACT = 0, M_READY = 1, M_MEMWAIT = 2, M_WB = 3, M_DONE = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic [IDB:0]   warp_count = '0;
  logic           fetch_done = 1'b0;
  logic           rd = 1'b0, wr = 1'b0, ret = 1'b0;
  logic [PCB-1:0] next_pc = '0;
  logic [NW-1:0]  mem_done = '0;
  logic           done, fetch_req_valid, mem_req_valid, wb_from_mem;
  logic [2:0]     core_state;
  logic [IDB-1:0] active_warp;
  logic [PCB-1:0] current_pc;
  logic [31:0]    issued_count, stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;

  warp_scheduler #(.NUM_WARPS(NW), .PC_BITS(PCB), .WARP_ID_BITS(IDB)) dut (
    .clk(clk), .reset(reset), .start(start), .warp_count(warp_count), .done(done),
    .core_state(core_state), .active_warp(active_warp), .current_pc(current_pc),
    .fetch_req_valid(fetch_req_valid), .fetch_done(fetch_done),
    .decoded_mem_read_enable(rd), .decoded_mem_write_enable(wr), .decoded_ret(ret),
    .next_pc(next_pc), .mem_req_valid(mem_req_valid), .mem_done(mem_done),
    .wb_from_mem(wb_from_mem), .issued_count(issued_count), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int cnt);
    reset = 1'b0; start = 1'b0; fetch_done = 1'b0; rd = 1'b0; wr = 1'b0; ret = 1'b0;
    mem_done = '0; next_pc = '0;
    tick();
    reset = 1'b1; warp_count = (IDB+1)'(cnt); start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(); tick();
    n_checks++;
    if ({core_state, active_warp, current_pc, done, fetch_req_valid, mem_req_valid,
         wb_from_mem, issued_count, stall_cycles} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: state=%0d warp=%0d pc=%0d done=%0d fetch=%0d mem=%0d wb=%0d iss=%0d stall=%0d, want all 0",
               core_state, active_warp, current_pc, done, fetch_req_valid, mem_req_valid,
               wb_from_mem, issued_count, stall_cycles);
    end
    reset = 1'b1;
  endtask

  task automatic test_zero_warps();
    bit saw_fetch = 0;
    launch(0);
    n_checks++;
    if (done !== 1'b1 || core_state !== 3'(S_DONE)) begin
      n_fail++; $display("FAIL zero_warps_done: done=%0d state=%0d, want 1/7", done, core_state);
    end
    for (int i = 0; i < 6; i++) begin
      start = 1'(i % 2);
      tick();
      if (fetch_req_valid) saw_fetch = 1;
    end
    start = 1'b0;
    n_checks++;
    if (saw_fetch || done !== 1'b1) begin
      n_fail++; $display("FAIL zero_warps_hold: fetch_seen=%0d done=%0d, want 0/1", saw_fetch, done);
    end
  endtask

  task automatic test_one_warp();
    int exp_s[6] = '{S_FETCH, S_DECODE, S_EXECUTE, S_UPDATE, S_SELECT, S_FETCH};
    launch(1);
    fetch_done = 1'b1; next_pc = 8'd5;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if (core_state !== 3'(exp_s[i])) begin
        n_fail++; $display("FAIL one_warp_seq[%0d]: got %0d, want %0d", i, core_state, exp_s[i]);
      end
    end
    n_checks++;
    if (current_pc !== 8'd5) begin
      n_fail++; $display("FAIL one_warp_branch_pc: got %0d, want 5", current_pc);
    end
    tick(); ret = 1'b1;
    tick(); ret = 1'b0;
    tick();
    n_checks++;
    if (done !== 1'b1 || issued_count !== 32'd2) begin
      n_fail++; $display("FAIL one_warp_ret: done=%0d issued=%0d, want 1/2", done, issued_count);
    end
  endtask

  task automatic test_rr_order();
    int order[$];
    int exp_o[6] = '{0, 1, 2, 3, 0, 1};
    launch(4);
    fetch_done = 1'b1;
    for (int i = 0; i < 40 && order.size() < 6; i++) begin
      tick();
      if (core_state == 3'(S_FETCH)) order.push_back(int'(active_warp));
    end
    n_checks++;
    if (order.size() != 6) begin
      n_fail++; $display("FAIL rr_grant_count: got %0d, want 6", order.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (order[i] != exp_o[i]) begin
          n_fail++; $display("FAIL rr_grant[%0d]: got %0d, want %0d", i, order[i], exp_o[i]);
        end
      end
    end
    n_checks++;
    if (stall_cycles !== 32'd0) begin
      n_fail++; $display("FAIL rr_stall: got %0d, want 0", stall_cycles);
    end
  endtask

  task automatic test_mem_wb();
    launch(2);
    fetch_done = 1'b1; next_pc = 8'd9;
    tick(); tick();
    rd = 1'b1;
    tick(); rd = 1'b0;
    n_checks++;
    if (core_state !== 3'(S_REQUEST) || mem_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL mem_request: state=%0d req=%0d, want 4/1", core_state, mem_req_valid);
    end
    tick();
    n_checks++;
    if (mem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL mem_req_one_cycle: got %0d, want 0", mem_req_valid);
    end
    tick();
    n_checks++;
    if (core_state !== 3'(S_FETCH) || active_warp !== 2'd1) begin
      n_fail++; $display("FAIL mem_next_warp: state=%0d warp=%0d, want 2/1", core_state, active_warp);
    end
    tick(); tick();
    mem_done = 4'b0001;
    tick(); mem_done = '0;
    tick(); tick();
    n_checks++;
    if (core_state !== 3'(S_UPDATE) || active_warp !== 2'd0 || wb_from_mem !== 1'b1 ||
        current_pc !== 8'd0) begin
      n_fail++; $display("FAIL mem_wb_grant: state=%0d warp=%0d wb=%0d pc=%0d, want 6/0/1/0",
                         core_state, active_warp, wb_from_mem, current_pc);
    end
    tick(); tick();
    n_checks++;
    if (active_warp !== 2'd1 || current_pc !== 8'd9) begin
      n_fail++; $display("FAIL mem_w1_pc: warp=%0d pc=%0d, want 1/9", active_warp, current_pc);
    end
    tick(); ret = 1'b1;
    tick(); ret = 1'b0;
    tick();
    n_checks++;
    if (active_warp !== 2'd0 || current_pc !== 8'd1) begin
      n_fail++; $display("FAIL mem_w0_pc: warp=%0d pc=%0d, want 0/1", active_warp, current_pc);
    end
  endtask

  task automatic test_wb_priority();
    launch(3);
    fetch_done = 1'b1;
    tick(); tick(); ret = 1'b1;
    tick(); ret = 1'b0;
    tick(); tick(); tick(); tick(); tick(); tick();
    n_checks++;
    if (core_state !== 3'(S_FETCH) || active_warp !== 2'd2) begin
      n_fail++; $display("FAIL prio_w2_fetch: state=%0d warp=%0d, want 2/2", core_state, active_warp);
    end
    tick(); wr = 1'b1;
    tick(); wr = 1'b0;
    tick(); tick();
    n_checks++;
    if (core_state !== 3'(S_FETCH) || active_warp !== 2'd1) begin
      n_fail++; $display("FAIL prio_w1_fetch: state=%0d warp=%0d, want 2/1", core_state, active_warp);
    end
    fetch_done = 1'b0; mem_done = 4'b0100;
    tick(); mem_done = '0; fetch_done = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    n_checks++;
    if (core_state !== 3'(S_UPDATE) || active_warp !== 2'd2 || wb_from_mem !== 1'b1) begin
      n_fail++; $display("FAIL prio_wb_first: state=%0d warp=%0d wb=%0d, want 6/2/1",
                         core_state, active_warp, wb_from_mem);
    end
  endtask

  task automatic test_stall_wrap();
    launch(1);
    fetch_done = 1'b1; next_pc = 8'd255;
    for (int i = 0; i < 6; i++) tick();
    n_checks++;
    if (current_pc !== 8'd255) begin
      n_fail++; $display("FAIL wrap_setup_pc: got %0d, want 255", current_pc);
    end
    tick(); rd = 1'b1;
    tick(); rd = 1'b0; mem_done = 4'b0001;
    tick(); mem_done = '0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_checks++;
      if (stall_cycles !== 32'(k) || core_state !== 3'(S_SELECT)) begin
        n_fail++; $display("FAIL stall_count[%0d]: stall=%0d state=%0d, want %0d/1", k, stall_cycles, core_state, k);
      end
    end
    mem_done = 4'b0001;
    tick(); mem_done = '0;
    tick();
    n_checks++;
    if (core_state !== 3'(S_UPDATE) || wb_from_mem !== 1'b1 || stall_cycles !== 32'd5) begin
      n_fail++; $display("FAIL stall_release: state=%0d wb=%0d stall=%0d, want 6/1/5",
                         core_state, wb_from_mem, stall_cycles);
    end
    tick(); tick();
    n_checks++;
    if (core_state !== 3'(S_FETCH) || current_pc !== 8'd0) begin
      n_fail++; $display("FAIL pc_wrap: state=%0d pc=%0d, want 2/0", core_state, current_pc);
    end
  endtask

  task automatic test_reset_mid_fetch();
    launch(2);
    fetch_done = 1'b0;
    tick(); tick();
    n_checks++;
    if (fetch_req_valid !== 1'b1) begin
      n_fail++; $display("FAIL midfetch_setup: fetch=%0d, want 1", fetch_req_valid);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({core_state, active_warp, current_pc, done, fetch_req_valid, mem_req_valid,
         wb_from_mem, issued_count, stall_cycles} !== '0) begin
      n_fail++; $display("FAIL midfetch_async_reset: state=%0d fetch=%0d pc=%0d, want 0",
                         core_state, fetch_req_valid, current_pc);
    end
    tick();
    reset = 1'b1;
  endtask

  task automatic test_random(input int runs);
    int mstate[NW]; int mpc[NW]; int rem[NW];
    int mptr, maw, mwb, issued_exp, stall_exp, cnt, st, st2, exp_st, gw, w, live;
    logic c_fd, c_rd, c_wr, c_ret;
    logic [PCB-1:0] c_np;
    logic [NW-1:0]  c_md;
    bit finished;
    for (int r = 0; r < runs; r++) begin
      cnt = $urandom_range(1, NW);
      for (int i = 0; i < NW; i++) begin
        mstate[i] = (i < cnt) ? M_READY : M_INACT;
        mpc[i] = 0;
        rem[i] = $urandom_range(0, 5);
      end
      mptr = 0; maw = 0; mwb = 0; issued_exp = 0; stall_exp = 0; finished = 0;
      launch(cnt);
      for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
        st = int'(core_state);
        fetch_done = 1'($urandom_range(0, 1));
        next_pc = PCB'($urandom);
        mem_done = NW'($urandom & $urandom);
        if (st == S_DECODE) begin
          if (rem[maw] == 0) begin
            ret = 1'b1; rd = 1'($urandom); wr = 1'($urandom);
          end else begin
            gw = $urandom_range(0, 2);
            ret = 1'b0; rd = (gw == 1); wr = (gw == 2);
            rem[maw]--;
          end
        end else begin
          ret = 1'($urandom); rd = 1'($urandom); wr = 1'($urandom);
        end
        n_checks++;
        if (fetch_req_valid !== (st == S_FETCH) || mem_req_valid !== (st == S_REQUEST)) begin
          n_fail++; $display("FAIL rand_req_flags: state=%0d fetch=%0d mem=%0d", st, fetch_req_valid, mem_req_valid);
        end
        c_fd = fetch_done; c_rd = rd; c_wr = wr; c_ret = ret; c_np = next_pc; c_md = mem_done;
        tick();
        st2 = int'(core_state);
        exp_st = S_SELECT;
        gw = -1;
        case (st)
          S_SELECT: begin
            for (int k = 0; k < NW; k++) begin
              w = (mptr + k) % NW;
              if (gw < 0 && mstate[w] == M_WB) gw = w;
            end
            if (gw >= 0) begin
              exp_st = S_UPDATE; mwb = 1;
            end else begin
              for (int k = 0; k < NW; k++) begin
                w = (mptr + k) % NW;
                if (gw < 0 && mstate[w] == M_READY) gw = w;
              end
              live = 0;
              for (int k = 0; k < NW; k++)
                if (mstate[k] == M_READY || mstate[k] == M_MEMWAIT || mstate[k] == M_WB) live = 1;
              if (gw >= 0) begin
                exp_st = S_FETCH; mwb = 0;
              end else if (live == 0) begin
                exp_st = S_DONE;
              end else begin
                exp_st = S_SELECT; stall_exp++;
              end
            end
            if (gw >= 0) begin
              maw = gw; mptr = (gw + 1) % NW;
              n_checks++;
              if (active_warp !== IDB'(gw) || current_pc !== PCB'(mpc[gw]) ||
                  wb_from_mem !== 1'(mwb)) begin
                n_fail++; $display("FAIL rand_grant: warp=%0d pc=%0d wb=%0d, want %0d/%0d/%0d",
                                   active_warp, current_pc, wb_from_mem, gw, mpc[gw], mwb);
              end
            end
          end
          S_FETCH:   exp_st = c_fd ? S_DECODE : S_FETCH;
          S_DECODE: begin
            issued_exp++;
            if (c_ret) begin
              mstate[maw] = M_DONE; exp_st = S_SELECT;
            end else if (c_rd || c_wr) begin
              exp_st = S_REQUEST;
            end else begin
              exp_st = S_EXECUTE;
            end
          end
          S_REQUEST: exp_st = S_SELECT;
          S_EXECUTE: exp_st = S_UPDATE;
          S_UPDATE: begin
            mstate[maw] = M_READY;
            mpc[maw] = (mwb != 0) ? (mpc[maw] + 1) % 256 : int'(c_np);
            exp_st = S_SELECT;
          end
          default:   exp_st = st;
        endcase
        for (int k = 0; k < NW; k++)
          if (c_md[k] && mstate[k] == M_MEMWAIT) mstate[k] = M_WB;
        if (st == S_REQUEST) mstate[maw] = M_MEMWAIT;
        n_checks++;
        if (st2 != exp_st) begin
          n_fail++; $display("FAIL rand_next_state: from %0d got %0d, want %0d", st, st2, exp_st);
        end
        if (st2 == S_DONE) finished = 1;
      end
      n_checks++;
      if (!finished || done !== 1'b1) begin
        n_fail++; $display("FAIL rand_finish[%0d]: done=%0d, want 1 within budget", r, done);
      end
      n_checks++;
      if (issued_count !== 32'(issued_exp) || stall_cycles !== 32'(stall_exp)) begin
        n_fail++; $display("FAIL rand_counters[%0d]: issued=%0d stall=%0d, want %0d/%0d",
                           r, issued_count, stall_cycles, issued_exp, stall_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_warps();
    test_one_warp();
    test_rr_order();
    test_mem_wb();
    test_wb_priority();
    test_stall_wrap();
    test_reset_mid_fetch();
    test_random(8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/warp_scheduler.md
# warp_scheduler

Multi-warp issue controller for the next-generation compute core. It interleaves up to NUM_WARPS warps over the core's single shared fetch/decode/execute path. A warp blocked on a data-memory access parks off-path while other warps keep issuing. It drives the shared pipeline state, the active-warp select and per-warp PCs, and counts issue and stall cycles.

## Interface
Parameters:
- NUM_WARPS, 4: warps resident per core (≥1).
- PC_BITS, 8: program counter width.
- WARP_ID_BITS, $clog2(NUM_WARPS) (min 1): warp index width.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  launch request; sampled in IDLE.
- warp_count  in  WARP_ID_BITS+1  number of active warps (0..NUM_WARPS).
- done  out  1  all active warps retired.
- core_state  out  3  shared pipe state: IDLE=0, SELECT=1, FETCH=2, DECODE=3, REQUEST=4, EXECUTE=5, UPDATE=6, DONE=7.
- active_warp  out  WARP_ID_BITS  warp that owns the pipe.
- current_pc  out  PC_BITS  PC of active_warp.
- fetch_req_valid  out  1  instruction fetch request.
- fetch_done  in  1  instruction available to the decoder.
- decoded_mem_read_enable, decoded_mem_write_enable, decoded_ret  in  1 each  decoder outputs, valid in DECODE.
- next_pc  in  PC_BITS  PC-unit result for active_warp, valid in UPDATE.
- mem_req_valid  out  1  one-cycle LSU launch for active_warp.
- mem_done  in  NUM_WARPS  per-warp memory completion pulse.
- wb_from_mem  out  1  in UPDATE: write back LSU data, not ALU data.
- issued_count  out  32  instructions decoded.
- stall_cycles  out  32  cycles spent in SELECT with nothing to pick.

## Operation
- Per-warp state: INACTIVE, READY, MEMWAIT, WB, DONE. Each warp holds a PC_BITS PC.
- IDLE: start=1 → warps 0..warp_count-1 go READY with PC 0, others INACTIVE → SELECT. warp_count=0 → straight to DONE.
- SELECT, in priority order:
  - any WB warp → grant one by round-robin, go to UPDATE with wb_from_mem=1.
  - else any READY warp → grant by round-robin, go to FETCH.
  - else all non-INACTIVE warps DONE → DONE.
  - else stay in SELECT and increment stall_cycles.
- Round-robin: one pointer shared by both request classes. Search starts at pointer and wraps. On any grant, pointer ← granted+1 mod NUM_WARPS.
- Grant loads active_warp, and loads current_pc from that warp's PC.
- FETCH: fetch_req_valid=1 until fetch_done=1 → DECODE. Zero-wait fetch_done is allowed.
- DECODE: one cycle, increments issued_count.
  - decoded_ret → warp DONE → SELECT. ret has priority over the memory enables.
  - a memory enable → REQUEST.
  - otherwise → EXECUTE.
- REQUEST: mem_req_valid=1 for one cycle; warp → MEMWAIT; pipe → SELECT.
- EXECUTE: one cycle → UPDATE.
- UPDATE: one cycle; warp → READY; → SELECT.
  - ALU path: warp PC ← next_pc.
  - memory writeback path: warp PC ← PC+1, modulo 2^PC_BITS (memory ops never branch).
- mem_done[w] with warp w in MEMWAIT → WB on the next edge. In any other warp state mem_done[w] is ignored. A pulse in the same cycle as that warp's REQUEST is ignored.
- DONE: done=1, held until reset; start is ignored.

## Timing
- Reset values: core_state=IDLE; active_warp=0; current_pc=0; all warp PCs 0; all warps INACTIVE; pointer 0; done, fetch_req_valid, mem_req_valid, wb_from_mem = 0; counters 0.
- Reset is asynchronous and acts immediately from any state, including mid-FETCH or with memory outstanding.
- All outputs are registered or decoded from registered state; there is no input→output combinational path.
- ALU instruction, zero-wait fetch: SELECT→FETCH→DECODE→EXECUTE→UPDATE→SELECT, 5 cycles.
- Memory instruction occupies the pipe for SELECT, FETCH, DECODE, REQUEST (4 cycles) plus a later SELECT→UPDATE pair (2 cycles).
- mem_done at edge t: the warp is eligible in SELECT from cycle t+1.
- Counters wrap at 2^32.

## Structure
- Shared package warp_sched_pkg holds:
  - the pipe_state_t and warp_state_t enums (core_state encoding as listed);
  - the 32-bit counter width constant.
- Sub-module rr_arbiter, parameterised by N. Inputs: request vector, pointer. Outputs: grant_valid, grant_index. It is combinational and instantiated twice (WB requests, READY requests).

## Test plan
- warp_count=0, start pulse → done=1 one cycle later; fetch_req_valid never asserts.
- 1 warp, ALU op with next_pc=5 → second FETCH shows current_pc=5. Next instruction decoded_ret → done=1; issued_count=2.
- 4 warps, all ALU ops, zero-wait fetch → active_warp grant order 0,1,2,3,0,1; stall_cycles=0.
- 2 warps, warp0 LDR → mem_req_valid one cycle, then warp1 FETCHes. mem_done[0] during warp1's EXECUTE → after warp1's UPDATE, SELECT grants warp0 UPDATE with wb_from_mem=1; warp0 PC 0→1.
- Warp2 in WB and warp1 READY in the same SELECT → UPDATE for warp2 first. 1 warp in MEMWAIT alone → stall_cycles increments each cycle until mem_done.
- Warp PC=255 (PC_BITS=8) completing a memory op → PC wraps to 0. reset driven low mid-FETCH → all outputs at reset values before the next clock edge.
